// File: rtl/pipe_valid_tracker.sv
// Tracks pipeline fill/drain around an upstream valid strobe: counts samples in to
// assert out_valid, holds it for DRAIN_CNT idle cycles afterwards, then pulses drain_done.
module pipe_valid_tracker #(
  parameter int FILL_CNT   = 4,
  parameter int DRAIN_CNT  = 4,
  parameter int SECOND_CNT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic out_valid,
  output logic out_second,
  output logic flushing,
  output logic drain_done
);

  localparam int MAX_CNT = (FILL_CNT > DRAIN_CNT) ? FILL_CNT : DRAIN_CNT;
  localparam int CW      = $clog2(MAX_CNT) + 1;

  localparam logic [CW-1:0] FILL_L   = CW'(FILL_CNT);
  localparam logic [CW-1:0] DRAIN_L  = CW'(DRAIN_CNT);
  localparam logic [CW-1:0] SECOND_L = CW'(SECOND_CNT);

  typedef enum logic [1:0] {IDLE, FILL, VALID, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          valid_d, second_d, done_d;

  assign cnt_inc = cnt_q + 1'b1;

  // NOTE: every always_comb target gets a default first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    valid_d  = out_valid;
    second_d = out_second;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          cnt_d    = CW'(1);
          second_d = (SECOND_CNT == 1);
          if (FILL_CNT == 1) begin
            state_d = VALID;
            valid_d = 1'b1;
            cnt_d   = '0;
          end else begin
            state_d = FILL;
          end
        end
      end

      FILL: begin
        if (in_valid) begin
          cnt_d = cnt_inc;
          if (cnt_inc == SECOND_L) second_d = 1'b1;
          if (cnt_inc == FILL_L) begin
            state_d = VALID;
            valid_d = 1'b1;
            cnt_d   = '0;
          end
        end else begin
          // A gap in the fill discards partial progress.
          state_d  = IDLE;
          cnt_d    = '0;
          second_d = 1'b0;
        end
      end

      VALID: begin
        if (!in_valid) begin
          if (DRAIN_CNT == 0) begin
            state_d  = IDLE;
            valid_d  = 1'b0;
            second_d = 1'b0;
            done_d   = 1'b1;
          end else begin
            state_d = DRAIN;
            cnt_d   = '0;
          end
        end
      end

      DRAIN: begin
        if (in_valid) begin
          // Pipeline contents are still live, so no refill is needed.
          state_d = VALID;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == DRAIN_L) begin
            state_d  = IDLE;
            cnt_d    = '0;
            valid_d  = 1'b0;
            second_d = 1'b0;
            done_d   = 1'b1;
          end
        end
      end

      default: begin
        state_d  = IDLE;
        cnt_d    = '0;
        valid_d  = 1'b0;
        second_d = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      out_valid  <= 1'b0;
      out_second <= 1'b0;
      flushing   <= 1'b0;
      drain_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      out_valid  <= valid_d;
      out_second <= second_d;
      flushing   <= (state_d == DRAIN);
      drain_done <= done_d;
    end
  end

endmodule

// File: tb/tb_pipe_valid_tracker.sv
// Scoreboard bench for pipe_valid_tracker: a run-length reference model predicts the
// outputs of two configurations each cycle; predictions are queued and popped after the edge.
module tb_pipe_valid_tracker;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;

  logic a_valid, a_second, a_flush, a_done;
  logic z_valid, z_second, z_flush, z_done;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  // Main configuration.
  pipe_valid_tracker #(.FILL_CNT(4), .DRAIN_CNT(3), .SECOND_CNT(2)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .out_valid(a_valid), .out_second(a_second), .flushing(a_flush), .drain_done(a_done)
  );

  // Corner configuration: zero drain, single-sample fill.
  pipe_valid_tracker #(.FILL_CNT(1), .DRAIN_CNT(0), .SECOND_CNT(1)) dut_z (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .out_valid(z_valid), .out_second(z_second), .flushing(z_flush), .drain_done(z_done)
  );

  // Reference model in run-length terms: consecutive highs while filling,
  // consecutive lows once filled.
  typedef struct {
    bit filled;
    int run;
    int low;
    bit ov, sec, fl, dd;
  } mdl_t;

  mdl_t ma, mz;
  logic [3:0] q_a[$];
  logic [3:0] q_z[$];

  function automatic mdl_t mdl_step(mdl_t m, bit r, bit iv, int fc, int dc, int sc);
    mdl_t n = m;
    n.dd = 1'b0;
    if (r) begin
      n.filled = 0; n.run = 0; n.low = 0;
      n.ov = 0; n.sec = 0; n.fl = 0;
    end else if (!n.filled) begin
      if (iv) begin
        n.run++;
        if (n.run == sc) n.sec = 1'b1;
        if (n.run == fc) begin
          n.filled = 1; n.ov = 1; n.low = 0;
        end
      end else begin
        n.run = 0; n.sec = 0;
      end
    end else begin
      if (iv) begin
        n.low = 0; n.fl = 0;
      end else begin
        n.low++;
        if (n.low > dc) begin
          n.filled = 0; n.run = 0; n.low = 0;
          n.ov = 0; n.sec = 0; n.fl = 0; n.dd = 1;
        end else begin
          n.fl = 1;
        end
      end
    end
    return n;
  endfunction

  function automatic logic [3:0] pack(mdl_t m);
    return {m.ov, m.sec, m.fl, m.dd};
  endfunction

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got {valid,second,flush,done}=%b expected %b", tag, got, exp);
    end
  endtask

  // Drive one cycle, queue the prediction, then compare once the edge has passed.
  task automatic step(input bit r, input bit iv);
    logic [3:0] ea, ez;
    rst      = r;
    in_valid = iv;
    ma = mdl_step(ma, r, iv, 4, 3, 2);
    mz = mdl_step(mz, r, iv, 1, 0, 1);
    q_a.push_back(pack(ma));
    q_z.push_back(pack(mz));
    @(posedge clk);
    #1;
    cyc++;
    ea = q_a.pop_front();
    ez = q_z.pop_front();
    check($sformatf("cfg_a cyc%0d", cyc), {a_valid, a_second, a_flush, a_done}, ea);
    check($sformatf("cfg_z cyc%0d", cyc), {z_valid, z_second, z_flush, z_done}, ez);
  endtask

  task automatic run(input bit r, input bit iv, input int n);
    for (int i = 0; i < n; i++) step(r, iv);
  endtask

  initial begin
    ma = '{default: 0};
    mz = '{default: 0};
    rst = 1'b1;
    in_valid = 1'b1;

    // Reset overrides in_valid.
    run(1, 1, 2);
    check("reset_state_a", {a_valid, a_second, a_flush, a_done}, 4'b0000);

    // Fill then drain.
    run(0, 1, 9);
    check("filled_a", {a_valid, a_second}, 4'b0011);
    run(0, 0, 3);
    check("draining_a", {a_valid, a_flush, a_done}, 4'b0110);
    step(0, 0);
    check("drain_done_a", {a_valid, a_second, a_flush, a_done}, 4'b0001);
    run(0, 0, 2);

    // Aborted fill.
    run(0, 1, 2);
    run(0, 0, 3);

    // Re-assert during drain.
    run(0, 1, 5);
    step(0, 0);
    run(0, 1, 3);
    check("reassert_a", {a_valid, a_flush, a_done}, 4'b0100);
    run(0, 0, 5);

    // Reset mid-VALID with in_valid high, then a fresh fill.
    run(0, 1, 6);
    step(1, 1);
    check("rst_valid_a", {a_valid, a_second, a_flush, a_done}, 4'b0000);
    run(0, 1, 3);
    check("refill_partial_a", {3'b000, a_valid}, 4'b0000);
    run(0, 1, 2);

    // Reset mid-DRAIN: no drain_done pulse afterwards.
    run(0, 0, 2);
    step(1, 0);
    run(0, 0, 4);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      bit r, iv;
      r  = ($urandom_range(0, 59) == 0);
      iv = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) iv = 1'b0;
      step(r, iv);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_valid_tracker.md
PIPE_VALID_TRACKER -- requirements
Module: pipe_valid_tracker

Interface
REQ-001 SHALL have parameter FILL_CNT, default 4: number of in_valid samples needed to fill the pipeline; legal range >= 1.
REQ-002 SHALL have parameter DRAIN_CNT, default 4: number of cycles out_valid is held after input stops; legal range >= 0.
REQ-003 SHALL have parameter SECOND_CNT, default 1: fill count that sets out_second; legal range 1..FILL_CNT.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port in_valid, input, 1 bit: upstream samples are valid this cycle.
REQ-007 SHALL have port out_valid, output, 1 bit: pipeline output is valid.
REQ-008 SHALL have port out_second, output, 1 bit: sticky flag; fill count has reached SECOND_CNT.
REQ-009 SHALL have port flushing, output, 1 bit: high while in DRAIN.
REQ-010 SHALL have port drain_done, output, 1 bit: one-cycle pulse on completion of a drain.

Function
REQ-011 SHALL implement FSM states IDLE, FILL, VALID, DRAIN; all outputs registered.
REQ-012 SHALL use an internal counter of width $clog2(max(FILL_CNT,DRAIN_CNT))+1; it SHALL NOT wrap in any legal sequence.
REQ-013 IDLE: an edge sampling in_valid=1 SHALL set cnt=1 and go to FILL, or go directly to VALID if FILL_CNT==1.
REQ-014 FILL: each edge sampling in_valid=1 SHALL increment cnt; on the edge where cnt reaches FILL_CNT, the block SHALL enter VALID and set out_valid=1.
REQ-015 FILL: an edge sampling in_valid=0 SHALL abort to IDLE, clearing cnt and out_second; out_valid stays 0.
REQ-016 out_second SHALL set on the edge where the fill count equals SECOND_CNT, and SHALL stay set until return to IDLE or reset.
REQ-017 VALID: out_valid=1; an edge sampling in_valid=0 SHALL enter DRAIN with cnt=0 and out_valid still 1. If DRAIN_CNT==0, the block SHALL instead go straight to IDLE with out_valid=0 and pulse drain_done.
REQ-018 DRAIN: each edge with in_valid=0 SHALL increment cnt; on the edge where cnt reaches DRAIN_CNT, the block SHALL go to IDLE, clear out_valid and out_second, and set drain_done=1 for exactly one cycle.
REQ-019 DRAIN: an edge sampling in_valid=1 SHALL return to VALID with cnt=0; out_valid SHALL stay 1 with no refill, and drain_done SHALL NOT pulse.
REQ-020 Net latency: with in_valid continuously high from edge k, out_valid SHALL be 1 after edge k+FILL_CNT-1. After in_valid is first sampled low at edge m, out_valid SHALL be 0 after edge m+DRAIN_CNT.
REQ-021 flushing SHALL equal (state==DRAIN), registered with the state.
REQ-022 drain_done SHALL be 0 in every cycle other than the one following a drain completion.

Reset
REQ-023 rst=1 at an edge SHALL force IDLE, cnt=0, out_valid=0, out_second=0, flushing=0, drain_done=0, overriding in_valid in every state.
REQ-024 Reset mid-FILL, mid-VALID or mid-DRAIN SHALL discard progress; no drain_done pulse SHALL occur.
REQ-025 Only the first edge with rst=0 SHALL sample in_valid.

Verification (FILL_CNT=4, DRAIN_CNT=3, SECOND_CNT=2 unless noted)
REQ-026 Fill: rst released, in_valid=1 from edge 1 -> out_second=1 after edge 2; out_valid=0 after edges 1-3 and 1 after edge 4.
REQ-027 Drain: continuing REQ-026, in_valid=0 from edge 10 -> flushing=1 after edges 10-12; out_valid=1 through edge 12 and 0 after edge 13; drain_done=1 only after edge 13; out_second=0 after edge 13.
REQ-028 Abort: in_valid=1 at edges 1-2, 0 at edge 3 -> out_second=1 after edge 2 and 0 after edge 3; out_valid never 1; IDLE after edge 3.
REQ-029 Re-assert: from VALID, in_valid=0 at edge 10 and 1 from edge 11 -> flushing=1 after edge 10 and 0 after edge 11; out_valid stays 1 throughout; drain_done never 1.
REQ-030 Reset mid-operation: in VALID, rst=1 at edge n with in_valid=1 -> all outputs 0 after edge n; after release, a new fill needs 4 in_valid samples.
REQ-031 Zero drain (DRAIN_CNT=0): from VALID, in_valid=0 at edge m -> out_valid=0 and drain_done=1 after edge m; flushing never 1.
